seq_pattern_gen: RTL and testbench

//  Serial pattern generator that drives the single-bit din of our Mealy sequence detectors.

---
 rtl/seq_pattern_gen.sv | 134 +++++++++++++
 tb/tb_seq_pattern_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator feeding a Mealy sequence detector. It also produces the detector's expected output.
// Optional feature macro: PATGEN_PARITY_EN appends an even-parity bit after each transmission.
module seq_pattern_gen #(
    parameter int WIDTH    = 8,
    parameter int REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [WIDTH-1:0]    pattern,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    output logic                dout,
    output logic                dout_valid,
    output logic                exp_mark,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [REPEAT_W-1:0] REP_ONE  = REPEAT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
`ifdef PATGEN_PARITY_EN
        S_PAR   = 3'd2,
`endif
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [WIDTH-1:0]    pat_q, pat_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [REPEAT_W-1:0] rep_left_q, rep_left_d;
    logic                ones_odd_q, ones_odd_d;

`ifdef PATGEN_PARITY_EN
    logic par_bit;
    assign par_bit = ^pat_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            pat_q      <= '0;
            bit_cnt_q  <= '0;
            rep_left_q <= '0;
            ones_odd_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            pat_q      <= pat_d;
            bit_cnt_q  <= bit_cnt_d;
            rep_left_q <= rep_left_d;
            ones_odd_q <= ones_odd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        pat_d      = pat_q;
        bit_cnt_d  = bit_cnt_q;
        rep_left_d = rep_left_q;
        ones_odd_d = ones_odd_q;
        load_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        dout       = 1'b0;
        dout_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                load_ready = 1'b1;
                busy       = 1'b0;
                if (load_valid) begin
                    shreg_d    = pattern;
                    pat_d      = pattern;
                    rep_left_d = repeat_cnt;
                    bit_cnt_d  = '0;
                    ones_odd_d = 1'b0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                dout       = shreg_q[WIDTH-1];
                dout_valid = 1'b1;
                shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
                bit_cnt_d  = bit_cnt_q + CNT_ONE;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
`ifdef PATGEN_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = (rep_left_q != '0) ? S_GAP : S_DONE;
`endif
                end
            end
`ifdef PATGEN_PARITY_EN
            S_PAR: begin
                dout       = par_bit;
                dout_valid = 1'b1;
                state_d    = (rep_left_q != '0) ? S_GAP : S_DONE;
            end
`endif
            S_GAP: begin
                // Reload here so the next repetition starts from the latched copy.
                rep_left_d = rep_left_q - REP_ONE;
                shreg_d    = pat_q;
                state_d    = S_SHIFT;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // ones_odd counts every transmitted 1, data or parity, across repetitions.
        if (dout_valid && dout) begin
            ones_odd_d = ~ones_odd_q;
        end
        exp_mark = dout_valid & dout & ~ones_odd_q;
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed table, hand sequences and randomized frames.
// Expected cycle streams come from a behavioural model of the frame format.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] pattern;
    logic [3:0] repeat_cnt;
    logic       dout;
    logic       dout_valid;
    logic       exp_mark;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    seq_pattern_gen #(.WIDTH(8), .REPEAT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .dout       (dout),
        .dout_valid (dout_valid),
        .exp_mark   (exp_mark),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

`ifdef PATGEN_PARITY_EN
    localparam int PAR_EXTRA = 1;
`else
    localparam int PAR_EXTRA = 0;
`endif

    typedef struct packed {
        logic dv;
        logic d;
        logic m;
        logic dn;
    } cyc_t;

    typedef struct {
        logic [7:0] pat;
        logic [3:0] rep;
        int         done_off;
        logic [7:0] bits;
        logic [7:0] marks;
        logic       par;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: MSB-first bits, optional parity, one gap between repetitions, then done.
    task automatic build_frame(input logic [7:0] pat, input logic [3:0] rep, output cyc_t q[$]);
        int ones = 0;
        logic b;
        q = {};
        for (int r = 0; r <= int'(rep); r++) begin
            for (int i = 7; i >= 0; i--) begin
                b = pat[i];
                q.push_back({1'b1, b, b && (ones % 2 == 0), 1'b0});
                if (b) ones++;
            end
            if (PAR_EXTRA == 1) begin
                b = ($countones(pat) % 2) == 1;
                q.push_back({1'b1, b, b && (ones % 2 == 0), 1'b0});
                if (b) ones++;
            end
            if (r < int'(rep)) q.push_back(4'b0000);
        end
        q.push_back(4'b0001);
    endtask

    task automatic run_frame(input logic [7:0] pat, input logic [3:0] rep, input bit hold,
                             input logic [7:0] hold_pat, output int done_off,
                             output logic [7:0] bits, output logic [7:0] marks, output logic par);
        cyc_t q[$];
        int   n = 0;
        done_off = 0;
        bits     = '0;
        marks    = '0;
        par      = 1'b0;
        @(negedge clk);
        while (load_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_ready", {28'd0, busy, load_ready, dout_valid, done}, 32'b0100);
        load_valid = 1'b1;
        pattern    = pat;
        repeat_cnt = rep;
        build_frame(pat, rep, q);
        @(posedge clk);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (hold) begin
                    pattern    = hold_pat;
                    repeat_cnt = 4'($urandom);
                end else begin
                    load_valid = 1'b0;
                    pattern    = 8'($urandom);
                end
            end
            chk("frame_cycle", {26'd0, load_ready, busy, dout_valid, dout, exp_mark, done},
                {26'd0, 1'b0, 1'b1, q[i].dv, q[i].d, q[i].m, q[i].dn});
            if (i < 8) begin
                bits[7-i]  = dout;
                marks[7-i] = exp_mark;
            end
            if (i == 8) par = dout;
            if (done === 1'b1 && done_off == 0) done_off = i + 1;
        end
        $display("frame pat=%02h rep=%0d hold=%0d done_off=%0d errors=%0d", pat, rep, hold, done_off, errors);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            chk("idle_quiet", {30'd0, busy, dout_valid}, 32'd0);
        end
    endtask

    vec_t       tbl[6];
    int         d_off;
    logic [7:0] got_bits;
    logic [7:0] got_marks;
    logic       got_par;

    initial begin
        tbl[0] = '{pat: 8'hB2, rep: 4'd0,  done_off: 9,   bits: 8'hB2, marks: 8'h90, par: 1'b0};
        tbl[1] = '{pat: 8'hB2, rep: 4'd1,  done_off: 18,  bits: 8'hB2, marks: 8'h90, par: 1'b0};
        tbl[2] = '{pat: 8'hFF, rep: 4'd0,  done_off: 9,   bits: 8'hFF, marks: 8'hAA, par: 1'b0};
        tbl[3] = '{pat: 8'h80, rep: 4'hF,  done_off: 144, bits: 8'h80, marks: 8'h80, par: 1'b1};
        tbl[4] = '{pat: 8'h01, rep: 4'd0,  done_off: 9,   bits: 8'h01, marks: 8'h01, par: 1'b1};
        tbl[5] = '{pat: 8'h00, rep: 4'd2,  done_off: 27,  bits: 8'h00, marks: 8'h00, par: 1'b0};

        rst        = 1'b1;
        load_valid = 1'b0;
        pattern    = '0;
        repeat_cnt = '0;
        @(negedge clk);
        chk("reset_state", {26'd0, load_ready, busy, dout_valid, dout, exp_mark, done}, 32'b100000);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            run_frame(tbl[t].pat, tbl[t].rep, 1'b0, 8'h00, d_off, got_bits, got_marks, got_par);
            chk("tbl_done_off", d_off, tbl[t].done_off + PAR_EXTRA * (int'(tbl[t].rep) + 1));
            chk("tbl_bits", {24'd0, got_bits}, {24'd0, tbl[t].bits});
            chk("tbl_marks", {24'd0, got_marks}, {24'd0, tbl[t].marks});
`ifdef PATGEN_PARITY_EN
            chk("tbl_parity", {31'd0, got_par}, {31'd0, tbl[t].par});
`endif
        end

        // load_valid held with a new pattern through a frame: accepted right after done.
        run_frame(8'h5A, 4'd0, 1'b1, 8'hC3, d_off, got_bits, got_marks, got_par);
        run_frame(8'hC3, 4'd0, 1'b0, 8'h00, d_off, got_bits, got_marks, got_par);
        chk("held_bits", {24'd0, got_bits}, 32'hC3);
        chk("held_marks", {24'd0, got_marks}, 32'h82);

        // Asynchronous reset in the middle of bit 4.
        @(negedge clk);
        load_valid = 1'b1;
        pattern    = 8'hB2;
        repeat_cnt = 4'd2;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst", {26'd0, load_ready, busy, dout_valid, dout, exp_mark, done}, 32'b100000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hold", {26'd0, load_ready, busy, dout_valid, dout, exp_mark, done}, 32'b100000);
        run_frame(8'hFF, 4'd0, 1'b0, 8'h00, d_off, got_bits, got_marks, got_par);
        chk("post_rst_marks", {24'd0, got_marks}, 32'hAA);
        chk("post_rst_done", d_off, 9 + PAR_EXTRA);

        // Randomized frames; the per-cycle model comparison does the checking.
        for (int k = 0; k < 40; k++) begin
            logic [7:0] rp;
            logic [3:0] rr;
            bit         hh;
            rp = 8'($urandom);
            rr = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            hh = bit'($urandom_range(0, 1));
            run_frame(rp, rr, hh, 8'($urandom), d_off, got_bits, got_marks, got_par);
            chk("rand_bits", {24'd0, got_bits}, {24'd0, rp});
            idle_cycles($urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
